// File: rtl/output_router_pkg.sv
// Shared types and constants for the flash output router.
//   state_t          : burst FSM states (IDLE, ROUTE, DRAIN, DONE)
//   DEST_SRAM/RXFIFO : fixed destination channel indices
//   dest_in_range()  : true when a requested channel index exists
package output_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEST_SRAM   = 0;
  localparam int DEST_RXFIFO = 1;

  // The SRAM and RX FIFO channels exist in every build (NUM_DEST >= 2);
  // spare slots exist only up to num_dest-1.
  function automatic logic dest_in_range(input int sel, input int num_dest);
    return (sel == DEST_SRAM) || (sel == DEST_RXFIFO) || (sel < num_dest);
  endfunction

endpackage

// File: rtl/output_router_if.sv
// Beat transport bundle between the flash return path, the router and the
// destination channels.
//   in_data/in_valid/in_ready       : flash beat stream into the router
//   dest_data/dest_valid/dest_ready : per-destination streams, slice i = dest i
//   master modport : environment side (flash source and destination sinks)
//   slave modport  : router side
interface output_router_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_DEST = 2
);
  logic [DATA_W-1:0]          in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_DEST*DATA_W-1:0] dest_data;
  logic [NUM_DEST-1:0]        dest_valid;
  logic [NUM_DEST-1:0]        dest_ready;

  modport master (
    output in_data, in_valid, dest_ready,
    input  in_ready, dest_data, dest_valid
  );

  modport slave (
    input  in_data, in_valid, dest_ready,
    output in_ready, dest_data, dest_valid
  );
endinterface

// File: rtl/output_router_fifo.sv
// Shared registered FIFO for the output router.
//   clk2, NReset : clock, asynchronous active-low reset
//   push, wdata  : write side (ignored when full)
//   pop, rdata   : read side, rdata is the current head (ignored when empty)
//   full, empty  : occupancy flags
//   one_left     : exactly one entry stored, so a pop now empties the FIFO
module output_router_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk2,
  input  logic              NReset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              one_left
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign one_left = (count == CNT_W'(1));
  assign rdata    = mem[rptr];

  // Depth is a power of two, so the pointers wrap by plain overflow; the
  // separate count tells full from empty when the pointers are equal.
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset: stale entries are unreachable once count is zero.
  always_ff @(posedge clk2) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/output_router.sv
// Flash output router: accepts a burst of flash read beats, buffers them in
// a shared FIFO and presents them on one latched destination channel.
//   clk2, NReset          : clock, asynchronous active-low reset
//   start                 : burst request, honoured in IDLE only
//   dest_sel, burst_len   : destination and beat count, latched on start
//   bus (slave)           : flash beat stream in, per-destination streams out
//   busy                  : FSM not in IDLE
//   done                  : one-cycle pulse at burst end
//   beat_count            : beats accepted in the current/last burst
//   err_unexp             : sticky "beat offered outside ROUTE" flag, present
//                           only when OUTPUT_ROUTER_UNEXP_EN is defined
module output_router
  import output_router_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DEST   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic                        clk2,
  input  logic                        NReset,
  input  logic                        start,
  input  logic [$clog2(NUM_DEST)-1:0] dest_sel,
  input  logic [LEN_W-1:0]            burst_len,
  output_router_if.slave              bus,
  output logic                        busy,
  output logic                        done,
  output logic [LEN_W-1:0]            beat_count
`ifdef OUTPUT_ROUTER_UNEXP_EN
  ,
  output logic                        err_unexp
`endif
);
  localparam int SEL_W = $clog2(NUM_DEST);

  state_t            state;
  state_t            state_next;
  logic [SEL_W-1:0]  dest_q;
  logic [LEN_W-1:0]  len_q;
  logic              start_acc;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_one_left;
  logic [DATA_W-1:0] head;

  assign start_acc    = (state == IDLE) & start;
  assign bus.in_ready = (state == ROUTE) & ~fifo_full;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = ~fifo_empty & bus.dest_ready[dest_q];
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  output_router_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk2     (clk2),
    .NReset   (NReset),
    .push     (push),
    .pop      (pop),
    .wdata    (bus.in_data),
    .rdata    (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .one_left (fifo_one_left)
  );

  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = (burst_len == '0) ? DONE : ROUTE;
      ROUTE: if (push && (beat_count + LEN_W'(1)) == len_q) state_next = DRAIN;
      // Leave on the pop of the last entry so DONE coincides with empty.
      DRAIN: if (pop && fifo_one_left) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      dest_q     <= '0;
      len_q      <= '0;
      beat_count <= '0;
    end else if (start_acc) begin
      dest_q     <= dest_in_range(int'(dest_sel), NUM_DEST) ? dest_sel : SEL_W'(DEST_SRAM);
      len_q      <= burst_len;
      beat_count <= '0;
    end else if (push && beat_count != len_q) begin
      beat_count <= beat_count + LEN_W'(1);
    end
  end

  // Only the latched channel sees the head; every other slice stays zero.
  always_comb begin
    bus.dest_data  = '0;
    bus.dest_valid = '0;
    if (!fifo_empty) begin
      bus.dest_valid[dest_q]                 = 1'b1;
      bus.dest_data[dest_q*DATA_W +: DATA_W] = head;
    end
  end

`ifdef OUTPUT_ROUTER_UNEXP_EN
  // A beat offered in the same cycle as an accepted start still counts as
  // unexpected, so the set takes priority over the clear.
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      err_unexp <= 1'b0;
    end else begin
      if (start_acc) err_unexp <= 1'b0;
      if (bus.in_valid && state != ROUTE) err_unexp <= 1'b1;
    end
  end
`endif

endmodule
